// File: rtl/smi_stream_ctrl.sv
// rtl/smi_stream_ctrl.sv - SMI byte-bus bridge for NUM_CH RX FIFOs, one TX FIFO and status registers
module smi_stream_ctrl #(
    parameter int         NUM_CH     = 2,
    parameter int         WORD_W     = 32,
    parameter logic [7:0] MODULE_VER = 8'h02
) (
    input  logic                     i_sys_clk,
    input  logic                     i_reset,
    input  logic [4:0]               i_ioc,
    input  logic [7:0]               i_data_in,
    output logic [7:0]               o_data_out,
    input  logic                     i_cs,
    input  logic                     i_fetch_cmd,
    input  logic                     i_load_cmd,
    output logic [NUM_CH-1:0]        o_rx_fifo_pull,
    input  logic [NUM_CH*WORD_W-1:0] i_rx_fifo_data,
    input  logic [NUM_CH-1:0]        i_rx_fifo_empty,
    input  logic [NUM_CH-1:0]        i_rx_fifo_full,
    output logic                     o_tx_fifo_push,
    output logic [WORD_W-1:0]        o_tx_fifo_data,
    input  logic                     i_tx_fifo_full,
    input  logic [2:0]               i_smi_a,
    input  logic                     i_smi_soe_se,
    input  logic                     i_smi_swe_srw,
    input  logic [7:0]               i_smi_data_in,
    output logic [7:0]               o_smi_data_out,
    output logic                     o_smi_read_req,
    output logic                     o_smi_write_req,
    output logic                     o_smi_writing
);

    localparam int            BPW    = WORD_W / 8;
    localparam int            CW     = $clog2(BPW + 1);
    localparam logic [CW-1:0] C_FULL = CW'(BPW);
    localparam logic [CW-1:0] C_LAST = CW'(BPW - 1);
    localparam logic [2:0]    C_NCH  = 3'(NUM_CH);

    logic              r_soe_s1, r_soe_s2, r_soe_d;
    logic              r_swe_s1, r_swe_s2, r_swe_d;
    logic              w_soe_fall, w_swe_rise;

    logic [WORD_W-1:0] r_hold [NUM_CH];
    logic [CW-1:0]     r_cnt  [NUM_CH];
    logic [NUM_CH-1:0] r_pull, r_load;
    logic [NUM_CH-1:0] w_sel_oh;
    logic              w_sel_ok;
    logic              w_avail;
    logic [7:0]        w_rd_byte;

    logic [WORD_W-1:0] r_acc, r_tx_data, w_acc_next;
    logic [CW-1:0]     r_tx_cnt;
    logic              r_tx_push, r_a2_d;
    logic              w_wr_byte, w_wr_last, w_mode_exit;

    logic [7:0]        r_err, w_err_set, w_err_clr, w_status;
    logic [7:0]        r_data_out, r_smi_data_out;
    logic              r_read_req, r_write_req;

    // Pad strobes are asynchronous: two sync flops plus a delayed copy for edge detection
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_soe_s1 <= 1'b0;
            r_soe_s2 <= 1'b0;
            r_soe_d  <= 1'b0;
            r_swe_s1 <= 1'b0;
            r_swe_s2 <= 1'b0;
            r_swe_d  <= 1'b0;
        end else begin
            r_soe_s1 <= i_smi_soe_se;
            r_soe_s2 <= r_soe_s1;
            r_soe_d  <= r_soe_s2;
            r_swe_s1 <= i_smi_swe_srw;
            r_swe_s2 <= r_swe_s1;
            r_swe_d  <= r_swe_s2;
        end
    end

    assign w_soe_fall  = r_soe_d & ~r_soe_s2;
    assign w_swe_rise  = r_swe_s2 & ~r_swe_d;
    assign w_sel_ok    = ~i_smi_a[2] && (i_smi_a < C_NCH);
    assign w_wr_byte   = w_swe_rise & i_smi_a[2];
    assign w_wr_last   = w_wr_byte & (r_tx_cnt == C_LAST);
    assign w_mode_exit = r_a2_d & ~i_smi_a[2];
    assign w_acc_next  = {r_acc[WORD_W-9:0], i_smi_data_in};

    // Channel select, current read byte (MSB first), availability and status/error set vectors
    always_comb begin
        w_sel_oh  = '0;
        w_rd_byte = 8'h00;
        w_avail   = 1'b0;
        w_status  = 8'h00;
        w_err_set = 8'h00;
        w_err_clr = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sel_oh[k] = w_sel_ok && (i_smi_a[1:0] == 2'(k));
            if (w_sel_oh[k] && (r_cnt[k] != '0))
                w_rd_byte = 8'(r_hold[k] >> {r_cnt[k] - 1'b1, 3'b000});
            if ((r_cnt[k] != '0) || !i_rx_fifo_empty[k])
                w_avail = 1'b1;
            w_status[2*k]     = i_rx_fifo_empty[k];
            w_status[2*k + 1] = i_rx_fifo_full[k];
            w_err_set[2 + k]  = w_soe_fall && w_sel_oh[k] && (r_cnt[k] == '0);
        end
        w_err_set[0] = w_soe_fall && ~i_smi_a[2] && ~w_sel_ok;
        w_err_set[1] = w_wr_last && i_tx_fifo_full;
        if (i_cs && i_load_cmd && (i_ioc == 5'd3))
            w_err_clr = i_data_in;
    end

    // Per-channel prefetch, load of the pulled word and byte countdown on SOE falling edges
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold[k] <= '0;
                r_cnt[k]  <= '0;
            end
            r_pull <= '0;
            r_load <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_pull[k] <= (r_cnt[k] == '0) && !i_rx_fifo_empty[k] && !r_pull[k] && !r_load[k];
                r_load[k] <= r_pull[k];
                if (r_load[k]) begin
                    r_hold[k] <= i_rx_fifo_data[k*WORD_W +: WORD_W];
                    r_cnt[k]  <= C_FULL;
                end else if (w_soe_fall && w_sel_oh[k] && (r_cnt[k] != '0)) begin
                    r_cnt[k] <= r_cnt[k] - 1'b1;
                end
            end
        end
    end

    // Byte packing into words; a full word is pushed unless the TX FIFO is full
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_tx_cnt  <= '0;
            r_tx_data <= '0;
            r_tx_push <= 1'b0;
            r_a2_d    <= 1'b0;
        end else begin
            r_a2_d    <= i_smi_a[2];
            r_tx_push <= 1'b0;
            if (w_mode_exit) begin
                r_acc    <= '0;
                r_tx_cnt <= '0;
            end else if (w_wr_byte) begin
                r_acc <= w_acc_next;
                if (w_wr_last) begin
                    r_tx_cnt <= '0;
                    if (!i_tx_fifo_full) begin
                        r_tx_push <= 1'b1;
                        r_tx_data <= w_acc_next;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset)
            r_err <= 8'h00;
        else
            r_err <= (r_err & ~w_err_clr) | w_err_set;
    end

    // Registered register-read port and SMI-side outputs
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data_out     <= 8'h00;
            r_smi_data_out <= 8'h00;
            r_read_req     <= 1'b0;
            r_write_req    <= 1'b0;
        end else begin
            r_smi_data_out <= w_rd_byte;
            r_read_req     <= w_avail;
            r_write_req    <= ~i_tx_fifo_full;
            if (i_cs && i_fetch_cmd) begin
                case (i_ioc)
                    5'd0:    r_data_out <= MODULE_VER;
                    5'd1:    r_data_out <= w_status;
                    5'd2:    r_data_out <= r_err;
                    default: r_data_out <= r_data_out;
                endcase
            end
        end
    end

    assign o_data_out      = r_data_out;
    assign o_rx_fifo_pull  = r_pull;
    assign o_tx_fifo_push  = r_tx_push;
    assign o_tx_fifo_data  = r_tx_data;
    assign o_smi_data_out  = r_smi_data_out;
    assign o_smi_read_req  = r_read_req;
    assign o_smi_write_req = r_write_req;
    assign o_smi_writing   = i_smi_a[2];

endmodule
